instr_fetch_unit: RTL and testbench

// Initiator side of the instruction path feeding the TSC control decoder. Issues word reads
// to instruction memory (readM/inputReady protocol), latches the returned 16-bit instruction,

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_if.sv | 39 +++
 rtl/instr_fetch_unit_pc_next_calc.sv | 30 +++
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the datapath widths, the fetch FSM state encoding, the default reset PC
// and a helper that sign-extends a branch offset to a full word.
// Opcode constants live with the decoder, not here.
package instr_fetch_unit_pkg;

  localparam int WORD_SIZE          = 16;
  localparam int OPCODE_SIZE        = 4;
  localparam int FUNCT_SIZE         = 6;
  localparam int JUMP_TARGET_SIZE   = 12;
  localparam int BRANCH_OFFSET_SIZE = 8;

  localparam logic [WORD_SIZE-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  // Two's complement branch immediate widened to an address-sized addend.
  function automatic logic [WORD_SIZE-1:0] sext_offset(
    input logic [BRANCH_OFFSET_SIZE-1:0] offset
  );
    return {{(WORD_SIZE-BRANCH_OFFSET_SIZE){offset[BRANCH_OFFSET_SIZE-1]}}, offset};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction path bus between the fetch unit and its neighbours.
// Memory side : mem_read, mem_address (out), mem_data, mem_input_ready (in).
// Decode side : instr, opcode, funct, instr_valid (out);
//               instr_ack, jump, jump_target, branch_taken, branch_offset, halt (in).
// The master modport is the fetch unit; the slave modport is memory/execute.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic                          mem_read;
  logic [WORD_SIZE-1:0]          mem_address;
  logic [WORD_SIZE-1:0]          mem_data;
  logic                          mem_input_ready;

  logic [WORD_SIZE-1:0]          instr;
  logic [OPCODE_SIZE-1:0]        opcode;
  logic [FUNCT_SIZE-1:0]         funct;
  logic                          instr_valid;
  logic                          instr_ack;
  logic                          jump;
  logic [JUMP_TARGET_SIZE-1:0]   jump_target;
  logic                          branch_taken;
  logic [BRANCH_OFFSET_SIZE-1:0] branch_offset;
  logic                          halt;

  modport master (
    output mem_read, mem_address,
    input  mem_data, mem_input_ready,
    output instr, opcode, funct, instr_valid,
    input  instr_ack, jump, jump_target, branch_taken, branch_offset, halt
  );

  modport slave (
    input  mem_read, mem_address,
    output mem_data, mem_input_ready,
    input  instr, opcode, funct, instr_valid,
    output instr_ack, jump, jump_target, branch_taken, branch_offset, halt
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection.
// Ports: pc, jump, jump_target, branch_taken, branch_offset (in) -> next_pc (out).
// Jump has priority over a taken branch; otherwise the PC advances by one.
// All arithmetic wraps modulo 2^WORD_SIZE.
module pc_next_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [WORD_SIZE-1:0]          pc,
  input  logic                          jump,
  input  logic [JUMP_TARGET_SIZE-1:0]   jump_target,
  input  logic                          branch_taken,
  input  logic [BRANCH_OFFSET_SIZE-1:0] branch_offset,
  output logic [WORD_SIZE-1:0]          next_pc
);

  logic [WORD_SIZE-1:0] pc_plus_one;

  assign pc_plus_one = pc + 16'd1;

  // A jump only replaces the low 12 bits, so it stays inside the current 4K page.
  always_comb begin
    next_pc = pc_plus_one;
    if (jump) begin
      next_pc = {pc[WORD_SIZE-1:JUMP_TARGET_SIZE], jump_target};
    end else if (branch_taken) begin
      next_pc = pc_plus_one + sext_offset(branch_offset);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads, latches the returned instruction,
// hands it to decode under a valid/ack handshake and steps the PC.
// Ports: clk, reset (sync, active high); bus (master modport of
// instr_fetch_unit_if: memory read channel and decode handshake);
// pc (current/being-fetched address), num_inst (retired count), halted.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_unit_if.master   bus,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted
);

  fetch_state_t         state;
  fetch_state_t         next_state;
  logic [WORD_SIZE-1:0] next_pc;
  logic [WORD_SIZE-1:0] instr_q;
  logic                 retire;

  pc_next_calc u_pc_next_calc (
    .pc            (pc),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .next_pc       (next_pc)
  );

  // An instruction retires only when decode acknowledges it while it is presented.
  assign retire = (state == ST_HOLD) && bus.instr_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory responses outside FETCH and acks outside HOLD fall through to the default.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   next_state = ST_FETCH;
      ST_FETCH:  if (bus.mem_input_ready) next_state = ST_HOLD;
      ST_HOLD:   if (bus.instr_ack) next_state = bus.halt ? ST_HALTED : ST_FETCH;
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Reset wins over a same-cycle memory response, so a late reply is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr_q  <= '0;
      num_inst <= '0;
    end else begin
      if ((state == ST_FETCH) && bus.mem_input_ready) begin
        instr_q <= bus.mem_data;
      end
      if (retire) begin
        pc       <= next_pc;
        num_inst <= num_inst + 16'd1;
      end
    end
  end

  always_comb begin
    bus.mem_read    = 1'b0;
    bus.instr_valid = 1'b0;
    halted          = 1'b0;
    case (state)
      ST_FETCH:  bus.mem_read    = 1'b1;
      ST_HOLD:   bus.instr_valid = 1'b1;
      ST_HALTED: halted          = 1'b1;
      default:   ;
    endcase
  end

  assign bus.mem_address = pc;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[WORD_SIZE-1:WORD_SIZE-OPCODE_SIZE];
  assign bus.funct       = instr_q[FUNCT_SIZE-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// Drives the memory and decode sides of the bus by hand and compares every
// observed output against hand-computed values.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] num_inst;
  logic        halted;

  int testsRun    = 0;
  int testsFailed = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.master),
    .pc       (pc),
    .num_inst (num_inst),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the rising edge, inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(
    input logic        ready,
    input logic [15:0] data,
    input logic        ack,
    input logic        jmp,
    input logic [11:0] target,
    input logic        br,
    input logic [7:0]  off,
    input logic        hlt
  );
    bus.mem_input_ready = ready;
    bus.mem_data        = data;
    bus.instr_ack       = ack;
    bus.jump            = jmp;
    bus.jump_target     = target;
    bus.branch_taken    = br;
    bus.branch_offset   = off;
    bus.halt            = hlt;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Deliver one instruction from FETCH and acknowledge it with the given next-PC controls.
  task automatic runInstr(
    input logic [15:0] data,
    input logic        jmp,
    input logic [11:0] target,
    input logic        br,
    input logic [7:0]  off,
    input logic        hlt
  );
    applyStimulus(1'b1, data, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1, jmp, target, br, off, hlt);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    checkOutput("rst_mem_read",    bus.mem_read,    16'h0000);
    checkOutput("rst_instr_valid", bus.instr_valid, 16'h0000);
    checkOutput("rst_halted",      halted,          16'h0000);
    checkOutput("rst_pc",          pc,              16'h0000);
    checkOutput("rst_num_inst",    num_inst,        16'h0000);
    checkOutput("rst_instr",       bus.instr,       16'h0000);
    checkOutput("rst_opcode",      bus.opcode,      16'h0000);

    reset = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      checkOutput("fetch0_mem_read", bus.mem_read,    16'h0001);
      checkOutput("fetch0_addr",     bus.mem_address, 16'h0000);
      checkOutput("fetch0_valid",    bus.instr_valid, 16'h0000);
      if (i < 2) tick();
    end

    applyStimulus(1'b1, 16'h6A05, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    checkOutput("hold_valid",    bus.instr_valid, 16'h0001);
    checkOutput("hold_opcode",   bus.opcode,      16'h0006);
    checkOutput("hold_funct",    bus.funct,       16'h0005);
    checkOutput("hold_instr",    bus.instr,       16'h6A05);
    checkOutput("hold_mem_read", bus.mem_read,    16'h0000);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 16'hDEAD ^ 16'(i), 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("bp_instr",    bus.instr,       16'h6A05);
      checkOutput("bp_mem_read", bus.mem_read,    16'h0000);
      checkOutput("bp_valid",    bus.instr_valid, 16'h0001);
      checkOutput("bp_pc",       pc,              16'h0000);
    end

    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    checkOutput("ack1_pc",       pc,              16'h0001);
    checkOutput("ack1_num_inst", num_inst,        16'h0001);
    checkOutput("ack1_mem_read", bus.mem_read,    16'h0001);
    checkOutput("ack1_addr",     bus.mem_address, 16'h0001);
    checkOutput("ack1_valid",    bus.instr_valid, 16'h0000);

    // Walk the PC page by page up to 0x3104 using in-page jumps and sequential carries.
    runInstr(16'h1000, 1'b1, 12'hFFF, 1'b0, 8'h00, 1'b0);
    checkOutput("walk_jmp_pc", pc, 16'h0FFF);
    runInstr(16'h1001, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    checkOutput("walk_carry_pc", pc, 16'h1000);
    runInstr(16'h1002, 1'b1, 12'hFFF, 1'b0, 8'h00, 1'b0);
    runInstr(16'h1003, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    checkOutput("walk_pc_2000", pc, 16'h2000);
    runInstr(16'h1004, 1'b1, 12'hFFF, 1'b0, 8'h00, 1'b0);
    runInstr(16'h1005, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    runInstr(16'h1006, 1'b1, 12'h104, 1'b0, 8'h00, 1'b0);
    checkOutput("walk_pc_3104", pc, 16'h3104);

    runInstr(16'h2007, 1'b1, 12'hABC, 1'b1, 8'h10, 1'b0);
    checkOutput("jmp_over_br_pc", pc,       16'h3ABC);
    checkOutput("jmp_num_inst",   num_inst, 16'h0009);

    // Reset lands in the same cycle as a memory response; the response must be lost.
    reset = 1'b1;
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("midrst_instr",    bus.instr,       16'h0000);
    checkOutput("midrst_valid",    bus.instr_valid, 16'h0000);
    checkOutput("midrst_mem_read", bus.mem_read,    16'h0000);
    checkOutput("midrst_pc",       pc,              16'h0000);
    checkOutput("midrst_num_inst", num_inst,        16'h0000);
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("midrst_refetch",  bus.mem_read,    16'h0001);
    checkOutput("midrst_addr",     bus.mem_address, 16'h0000);
    checkOutput("midrst_instr2",   bus.instr,       16'h0000);

    applyStimulus(1'b1, 16'h4C3F, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("br_opcode", bus.opcode, 16'h0004);
    checkOutput("br_funct",  bus.funct,  16'h003F);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 12'h000, 1'b1, 8'hFE, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    checkOutput("br_neg_wrap_pc", pc, 16'hFFFF);

    runInstr(16'h0001, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    checkOutput("seq_wrap_pc",   pc,       16'h0000);
    checkOutput("seq_num_inst",  num_inst, 16'h0002);

    runInstr(16'h0002, 1'b0, 12'h000, 1'b1, 8'h05, 1'b0);
    checkOutput("br_pos_pc", pc, 16'h0006);

    runInstr(16'h0003, 1'b1, 12'h010, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_halt_pc", pc, 16'h0010);

    runInstr(16'hF000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1);
    checkOutput("halt_pc",       pc,           16'h0011);
    checkOutput("halt_halted",   halted,       16'h0001);
    checkOutput("halt_mem_read", bus.mem_read, 16'h0000);
    checkOutput("halt_num_inst", num_inst,     16'h0005);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 12'h777, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("halted_pc",       pc,              16'h0011);
      checkOutput("halted_num_inst", num_inst,        16'h0005);
      checkOutput("halted_mem_read", bus.mem_read,    16'h0000);
      checkOutput("halted_valid",    bus.instr_valid, 16'h0000);
      checkOutput("halted_flag",     halted,          16'h0001);
    end

    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("unhalt_pc",       pc,       16'h0000);
    checkOutput("unhalt_num_inst", num_inst, 16'h0000);
    checkOutput("unhalt_halted",   halted,   16'h0000);
    reset = 1'b0;
    tick();
    checkOutput("unhalt_mem_read", bus.mem_read,    16'h0001);
    checkOutput("unhalt_addr",     bus.mem_address, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
